// File: rtl/axi_seq_pkg.sv
// Shared state, transfer and status encodings for the AXI command sequencer.
package axi_seq_pkg;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_BUSY  = 2'd2,
    S_CLEAR = 2'd3
  } state_e;

  localparam logic [1:0] RW_NOP   = 2'b00;
  localparam logic [1:0] RW_WRITE = 2'b01;
  localparam logic [1:0] RW_READ  = 2'b10;

  typedef enum logic [1:0] {
    ST_OK      = 2'b00,
    ST_ERROR   = 2'b01,
    ST_INVALID = 2'b10
  } rsp_status_e;

  localparam logic [2:0] SIZE_BYTE  = 3'd0;
  localparam logic [2:0] SIZE_HALF  = 3'd1;
  localparam logic [2:0] SIZE_WORD  = 3'd2;
  localparam logic [2:0] SIZE_DWORD = 3'd3;

  // An invalid request outranks a bus error when both are flagged.
  function automatic rsp_status_e rsp_status(input logic invalid, input logic error);
    rsp_status_e st;
    if (invalid) begin
      st = ST_INVALID;
    end else if (error) begin
      st = ST_ERROR;
    end else begin
      st = ST_OK;
    end
    return st;
  endfunction

endpackage

// File: rtl/axi_seq_chk.sv
// Runtime checks on the sequencer's FIFO occupancy.
module axi_seq_chk #(
  parameter int CMD_DEPTH = 4,
  parameter int RSP_DEPTH = 4
) (
  input logic                       i_clk,
  input logic                       i_rst,
  input logic                       rsp_push,
  input logic                       rsp_full,
  input logic [$clog2(RSP_DEPTH):0] rsp_count,
  input logic [$clog2(CMD_DEPTH):0] cmd_count
);
  localparam int RCW = $clog2(RSP_DEPTH) + 1;
  localparam int CCW = $clog2(CMD_DEPTH) + 1;

  a_rsp_no_overflow: assert property (@(posedge i_clk) disable iff (i_rst)
    !(rsp_push && rsp_full));

  a_rsp_count_range: assert property (@(posedge i_clk) disable iff (i_rst)
    rsp_count <= RCW'(RSP_DEPTH));

  a_cmd_count_range: assert property (@(posedge i_clk) disable iff (i_rst)
    cmd_count <= CCW'(CMD_DEPTH));

endmodule

// File: rtl/sync_fifo.sv
// Single-clock FIFO with register storage; the head entry is read straight from storage.
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                   i_clk,
  input  logic                   i_rst,
  input  logic                   push,
  input  logic [WIDTH-1:0]       push_data,
  input  logic                   pop,
  output logic [WIDTH-1:0]       head,
  output logic                   full,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] count
);
  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_r [DEPTH];
  logic [AW-1:0]    wr_ptr_r;
  logic [AW-1:0]    rd_ptr_r;
  logic [AW:0]      count_r;
  logic             push_s;
  logic             pop_s;

  // A push into a full FIFO is dropped even if a pop happens in the same cycle.
  assign push_s = push && !full;
  assign pop_s  = pop && !empty;
  assign full   = (count_r == (AW+1)'(DEPTH));
  assign empty  = (count_r == (AW+1)'(0));
  assign count  = count_r;
  assign head   = mem_r[rd_ptr_r];

  // Storage writes, pointer advance and occupancy tracking.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_r[i] <= {WIDTH{1'b0}};
      end
      wr_ptr_r <= {AW{1'b0}};
      rd_ptr_r <= {AW{1'b0}};
      count_r  <= {(AW+1){1'b0}};
    end else begin
      if (push_s) begin
        mem_r[wr_ptr_r] <= push_data;
        wr_ptr_r        <= wr_ptr_r + AW'(1);
      end
      if (pop_s) begin
        rd_ptr_r <= rd_ptr_r + AW'(1);
      end
      if (push_s && !pop_s) begin
        count_r <= count_r + (AW+1)'(1);
      end else if (pop_s && !push_s) begin
        count_r <= count_r - (AW+1)'(1);
      end
    end
  end

endmodule

// File: rtl/axi_cmd_sequencer.sv
// Command front-end for the single-beat AXI master: queues tagged commands,
// issues them one at a time and returns tagged responses.
module axi_cmd_sequencer
  import axi_seq_pkg::*;
#(
  parameter int CMD_DEPTH = 4,
  parameter int RSP_DEPTH = 4,
  parameter int TAG_W     = 4
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             s_cmd_valid,
  output logic             s_cmd_ready,
  input  logic             s_cmd_read,
  input  logic [2:0]       s_cmd_size,
  input  logic [31:0]      s_cmd_addr,
  input  logic [63:0]      s_cmd_wdata,
  input  logic [TAG_W-1:0] s_cmd_tag,
  output logic             m_rsp_valid,
  input  logic             m_rsp_ready,
  output logic [63:0]      m_rsp_rdata,
  output logic [1:0]       m_rsp_status,
  output logic             m_rsp_read,
  output logic [TAG_W-1:0] m_rsp_tag,
  output logic [1:0]       o_rw,
  output logic [2:0]       o_size,
  output logic [31:0]      o_addr,
  output logic [63:0]      o_wdata,
  output logic             o_clear,
  input  logic [63:0]      i_rdata,
  input  logic             i_wait,
  input  logic             i_done,
  input  logic             i_error,
  input  logic             i_invalid,
  output logic             o_busy,
  output logic [15:0]      o_err_count
);
  localparam int CMD_W = 1 + 3 + 32 + 64 + TAG_W;
  localparam int RSP_W = 64 + 2 + 1 + TAG_W;
  localparam int CCW   = $clog2(CMD_DEPTH) + 1;
  localparam int RCW   = $clog2(RSP_DEPTH) + 1;

  state_e             state_r;
  state_e             state_nxt_s;
  logic               cmd_push_s;
  logic               cmd_pop_s;
  logic               cmd_full_s;
  logic               cmd_empty_s;
  logic [CCW-1:0]     cmd_count_s;
  logic [CMD_W-1:0]   cmd_head_s;
  logic               rsp_push_s;
  logic               rsp_full_s;
  logic               rsp_empty_s;
  logic [RCW-1:0]     rsp_count_s;
  logic [RSP_W-1:0]   rsp_head_s;
  logic [RSP_W-1:0]   rsp_data_s;
  logic [63:0]        rsp_rdata_s;
  rsp_status_e        rsp_status_s;
  logic               xfer_done_s;

  logic               hd_read_s;
  logic [2:0]         hd_size_s;
  logic [31:0]        hd_addr_s;
  logic [63:0]        hd_wdata_s;
  logic [TAG_W-1:0]   hd_tag_s;

  logic [1:0]         rw_r;
  logic [2:0]         size_r;
  logic [31:0]        addr_r;
  logic [63:0]        wdata_r;
  logic               read_r;
  logic [TAG_W-1:0]   tag_r;
  logic               clear_r;
  logic [15:0]        err_cnt_r;

  assign cmd_push_s = s_cmd_valid && !cmd_full_s;
  assign s_cmd_ready = !cmd_full_s;
  assign {hd_read_s, hd_size_s, hd_addr_s, hd_wdata_s, hd_tag_s} = cmd_head_s;

  sync_fifo #(.WIDTH(CMD_W), .DEPTH(CMD_DEPTH)) u_cmd_fifo (
    .i_clk     (i_clk),
    .i_rst     (i_rst),
    .push      (cmd_push_s),
    .push_data ({s_cmd_read, s_cmd_size, s_cmd_addr, s_cmd_wdata, s_cmd_tag}),
    .pop       (cmd_pop_s),
    .head      (cmd_head_s),
    .full      (cmd_full_s),
    .empty     (cmd_empty_s),
    .count     (cmd_count_s)
  );

  // Completion data is only meaningful in the cycle the master reports done.
  assign xfer_done_s  = i_done && !i_wait;
  assign rsp_rdata_s  = read_r ? i_rdata : 64'd0;
  assign rsp_status_s = rsp_status(i_invalid, i_error);
  assign rsp_data_s   = {rsp_rdata_s, rsp_status_s, read_r, tag_r};

  sync_fifo #(.WIDTH(RSP_W), .DEPTH(RSP_DEPTH)) u_rsp_fifo (
    .i_clk     (i_clk),
    .i_rst     (i_rst),
    .push      (rsp_push_s),
    .push_data (rsp_data_s),
    .pop       (m_rsp_ready),
    .head      (rsp_head_s),
    .full      (rsp_full_s),
    .empty     (rsp_empty_s),
    .count     (rsp_count_s)
  );

  assign m_rsp_valid = !rsp_empty_s;
  assign {m_rsp_rdata, m_rsp_status, m_rsp_read, m_rsp_tag} = rsp_head_s;

  // Next-state, command pop and response push decisions.
  always_comb begin
    state_nxt_s = state_r;
    cmd_pop_s   = 1'b0;
    rsp_push_s  = 1'b0;
    case (state_r)
      S_IDLE: begin
        if (!cmd_empty_s && !rsp_full_s) begin
          cmd_pop_s   = 1'b1;
          state_nxt_s = S_ISSUE;
        end else begin
          state_nxt_s = S_IDLE;
        end
      end
      S_ISSUE, S_BUSY: begin
        if (xfer_done_s) begin
          rsp_push_s  = 1'b1;
          state_nxt_s = S_CLEAR;
        end else begin
          state_nxt_s = S_BUSY;
        end
      end
      S_CLEAR: state_nxt_s = S_IDLE;
      default: state_nxt_s = S_IDLE;
    endcase
  end

  // State register plus request/clear outputs, registered so they line up with the state.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_r <= S_IDLE;
      rw_r    <= RW_NOP;
      size_r  <= 3'd0;
      addr_r  <= 32'd0;
      wdata_r <= 64'd0;
      read_r  <= 1'b0;
      tag_r   <= {TAG_W{1'b0}};
      clear_r <= 1'b0;
    end else begin
      state_r <= state_nxt_s;
      clear_r <= (state_nxt_s == S_CLEAR);
      if (cmd_pop_s) begin
        rw_r    <= hd_read_s ? RW_READ : RW_WRITE;
        size_r  <= hd_size_s;
        addr_r  <= hd_addr_s;
        wdata_r <= hd_wdata_s;
        read_r  <= hd_read_s;
        tag_r   <= hd_tag_s;
      end else begin
        rw_r <= RW_NOP;
      end
    end
  end

  // Saturating count of non-OK responses.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      err_cnt_r <= 16'd0;
    end else if (rsp_push_s && (rsp_status_s != ST_OK) && (err_cnt_r != 16'hFFFF)) begin
      err_cnt_r <= err_cnt_r + 16'd1;
    end
  end

  assign o_rw        = rw_r;
  assign o_size      = size_r;
  assign o_addr      = addr_r;
  assign o_wdata     = wdata_r;
  assign o_clear     = clear_r;
  assign o_err_count = err_cnt_r;
  assign o_busy      = (state_r != S_IDLE) || (cmd_count_s != CCW'(0));

  axi_seq_chk #(.CMD_DEPTH(CMD_DEPTH), .RSP_DEPTH(RSP_DEPTH)) u_chk (
    .i_clk     (i_clk),
    .i_rst     (i_rst),
    .rsp_push  (rsp_push_s),
    .rsp_full  (rsp_full_s),
    .rsp_count (rsp_count_s),
    .cmd_count (cmd_count_s)
  );

endmodule

// File: tb/tb_axi_cmd_sequencer.sv
// Scoreboard bench: stimulus queues expected master requests and responses;
// a master model and a response monitor pop and compare independently.
module tb_axi_cmd_sequencer;
  localparam int TAG_W = 4;

  logic             i_clk = 1'b0;
  logic             i_rst = 1'b1;
  logic             s_cmd_valid = 1'b0;
  logic             s_cmd_ready;
  logic             s_cmd_read = 1'b0;
  logic [2:0]       s_cmd_size = 3'd0;
  logic [31:0]      s_cmd_addr = 32'd0;
  logic [63:0]      s_cmd_wdata = 64'd0;
  logic [TAG_W-1:0] s_cmd_tag = 4'd0;
  logic             m_rsp_valid;
  logic             m_rsp_ready = 1'b1;
  logic [63:0]      m_rsp_rdata;
  logic [1:0]       m_rsp_status;
  logic             m_rsp_read;
  logic [TAG_W-1:0] m_rsp_tag;
  logic [1:0]       o_rw;
  logic [2:0]       o_size;
  logic [31:0]      o_addr;
  logic [63:0]      o_wdata;
  logic             o_clear;
  logic [63:0]      i_rdata;
  logic             i_wait;
  logic             i_done;
  logic             i_error;
  logic             i_invalid;
  logic             o_busy;
  logic [15:0]      o_err_count;

  typedef struct {
    logic [1:0]  rw;
    logic [2:0]  size;
    logic [31:0] addr;
    logic [63:0] wdata;
    int          lat;
    logic [63:0] rdata;
    logic        err;
    logic        inv;
  } plan_t;

  typedef struct {
    logic [63:0]      rdata;
    logic [1:0]       status;
    logic             read;
    logic [TAG_W-1:0] tag;
  } rsp_t;

  plan_t       plan_q[$];
  rsp_t        sb_q[$];
  int          n_tests = 0;
  int          n_fail  = 0;
  int          issued  = 0;
  logic [15:0] exp_err = 16'd0;

  axi_cmd_sequencer #(.CMD_DEPTH(4), .RSP_DEPTH(4), .TAG_W(TAG_W)) dut (
    .i_clk(i_clk), .i_rst(i_rst),
    .s_cmd_valid(s_cmd_valid), .s_cmd_ready(s_cmd_ready), .s_cmd_read(s_cmd_read),
    .s_cmd_size(s_cmd_size), .s_cmd_addr(s_cmd_addr), .s_cmd_wdata(s_cmd_wdata),
    .s_cmd_tag(s_cmd_tag),
    .m_rsp_valid(m_rsp_valid), .m_rsp_ready(m_rsp_ready), .m_rsp_rdata(m_rsp_rdata),
    .m_rsp_status(m_rsp_status), .m_rsp_read(m_rsp_read), .m_rsp_tag(m_rsp_tag),
    .o_rw(o_rw), .o_size(o_size), .o_addr(o_addr), .o_wdata(o_wdata), .o_clear(o_clear),
    .i_rdata(i_rdata), .i_wait(i_wait), .i_done(i_done), .i_error(i_error),
    .i_invalid(i_invalid), .o_busy(o_busy), .o_err_count(o_err_count)
  );

  always #5 i_clk = ~i_clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Drive one command and hold it until the FIFO accepts it (bounded).
  task automatic push_cmd(input logic rd, input logic [2:0] sz, input logic [31:0] ad,
                          input logic [63:0] wd, input logic [TAG_W-1:0] tg);
    int   n;
    logic acc;
    s_cmd_valid = 1'b1;
    s_cmd_read  = rd;
    s_cmd_size  = sz;
    s_cmd_addr  = ad;
    s_cmd_wdata = wd;
    s_cmd_tag   = tg;
    n   = 0;
    acc = 1'b0;
    while (!acc && n < 200) begin
      @(negedge i_clk);
      acc = s_cmd_ready;
      @(posedge i_clk);
      #1;
      n++;
    end
    if (!acc) check("cmd_accept_timeout", 64'(acc), 64'd1);
    s_cmd_valid = 1'b0;
  endtask

  // Queue the master behaviour and hand-computed response, then push the command.
  task automatic send(input logic rd, input logic [2:0] sz, input logic [31:0] ad,
                      input logic [63:0] wd, input logic [TAG_W-1:0] tg, input int lat,
                      input logic [63:0] mrdata, input logic merr, input logic minv,
                      input logic [63:0] exp_rdata, input logic [1:0] exp_st);
    plan_t p;
    rsp_t  r;
    p.rw = rd ? 2'b10 : 2'b01;
    p.size = sz; p.addr = ad; p.wdata = wd; p.lat = lat;
    p.rdata = mrdata; p.err = merr; p.inv = minv;
    plan_q.push_back(p);
    r.rdata = exp_rdata; r.status = exp_st; r.read = rd; r.tag = tg;
    sb_q.push_back(r);
    if (exp_st != 2'b00 && exp_err != 16'hFFFF) exp_err = exp_err + 16'd1;
    push_cmd(rd, sz, ad, wd, tg);
  endtask

  task automatic wait_idle(input string name);
    int n;
    n = 0;
    @(negedge i_clk);
    while ((o_busy || sb_q.size() != 0) && n < 500) begin
      @(negedge i_clk);
      n++;
    end
    check(name, 64'(o_busy || sb_q.size() != 0), 64'd0);
    @(posedge i_clk);
    #1;
  endtask

  // Master model: sees o_rw at the falling edge and answers per the queued plan.
  initial begin
    int    mst_st;
    int    cnt;
    plan_t p;
    mst_st = 0; cnt = 0;
    i_done = 1'b0; i_wait = 1'b0; i_rdata = 64'd0; i_error = 1'b0; i_invalid = 1'b0;
    forever begin
      @(negedge i_clk);
      if (i_rst) begin
        mst_st = 0;
        i_done = 1'b0; i_wait = 1'b0; i_error = 1'b0; i_invalid = 1'b0;
      end else begin
        case (mst_st)
          0: if (o_rw != 2'b00) begin
               issued++;
               if (plan_q.size() == 0) begin
                 check("unexpected_issue", 64'(plan_q.size()), 64'd1);
               end else begin
                 p = plan_q.pop_front();
                 check("issue_rw", 64'(o_rw), 64'(p.rw));
                 check("issue_size", 64'(o_size), 64'(p.size));
                 check("issue_addr", 64'(o_addr), 64'(p.addr));
                 check("issue_wdata", o_wdata, p.wdata);
                 if (p.lat == 0) begin
                   i_done = 1'b1; i_rdata = p.rdata; i_error = p.err; i_invalid = p.inv;
                   mst_st = 2;
                 end else begin
                   i_wait = 1'b1; cnt = p.lat; mst_st = 1;
                 end
               end
             end
          1: begin
               check("rw_single_cycle", 64'(o_rw), 64'd0);
               cnt--;
               if (cnt == 0) begin
                 i_wait = 1'b0; i_done = 1'b1;
                 i_rdata = p.rdata; i_error = p.err; i_invalid = p.inv;
                 mst_st = 2;
               end
             end
          2: begin
               check("clear_pulse", 64'(o_clear), 64'd1);
               check("rw_in_clear", 64'(o_rw), 64'd0);
               i_done = 1'b0; i_error = 1'b0; i_invalid = 1'b0; i_rdata = 64'd0;
               mst_st = 3;
             end
          3: begin
               check("clear_one_cycle", 64'(o_clear), 64'd0);
               mst_st = 0;
             end
          default: mst_st = 0;
        endcase
      end
    end
  end

  // Response monitor: compares each consumed response against the scoreboard.
  initial begin
    rsp_t r;
    forever begin
      @(negedge i_clk);
      if (!i_rst && m_rsp_valid && m_rsp_ready) begin
        if (sb_q.size() == 0) begin
          check("unexpected_rsp", 64'(sb_q.size()), 64'd1);
        end else begin
          r = sb_q.pop_front();
          check("rsp_rdata", m_rsp_rdata, r.rdata);
          check("rsp_status", 64'(m_rsp_status), 64'(r.status));
          check("rsp_read", 64'(m_rsp_read), 64'(r.read));
          check("rsp_tag", 64'(m_rsp_tag), 64'(r.tag));
        end
      end
    end
  end

  initial begin
    #300000;
    $display("FAIL watchdog: run did not complete, got timeout, expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int base;
    repeat (3) @(negedge i_clk);
    check("rst_rw", 64'(o_rw), 64'd0);
    check("rst_cmd_ready", 64'(s_cmd_ready), 64'd1);
    check("rst_rsp_valid", 64'(m_rsp_valid), 64'd0);
    check("rst_err_count", 64'(o_err_count), 64'd0);
    check("rst_busy", 64'(o_busy), 64'd0);
    check("rst_clear", 64'(o_clear), 64'd0);
    check("rst_addr", 64'(o_addr), 64'd0);
    @(posedge i_clk); #1;
    i_rst = 1'b0;
    @(posedge i_clk); #1;

    // Aligned write, 5-cycle completion; read data must be zeroed for writes.
    send(1'b0, 3'd2, 32'h1000_0004, 64'hDEAD_BEEF, 4'd3, 5,
         64'hA5A5_A5A5_A5A5_A5A5, 1'b0, 1'b0, 64'd0, 2'b00);
    wait_idle("t1_idle");
    check("t1_err_count", 64'(o_err_count), 64'(exp_err));

    // Dword read.
    send(1'b1, 3'd3, 32'h2000_0000, 64'd0, 4'd7, 3,
         64'h0123_4567_89AB_CDEF, 1'b0, 1'b0, 64'h0123_4567_89AB_CDEF, 2'b00);
    wait_idle("t2_idle");
    check("t2_err_count", 64'(o_err_count), 64'd0);

    // Misaligned half: completes in the issue cycle, invalid outranks error.
    send(1'b0, 3'd1, 32'h0000_1001, 64'h0000_BEEF, 4'd5, 0,
         64'h1111_2222_3333_4444, 1'b1, 1'b1, 64'd0, 2'b10);
    wait_idle("t3_idle");
    check("t3_err_count", 64'(o_err_count), 64'd1);

    // Back-pressure: response FIFO fills after 4 transfers.
    base = issued;
    m_rsp_ready = 1'b0;
    for (int i = 0; i < 6; i++) begin
      send(1'b1, 3'd2, 32'h3000_0000 + 32'(i * 4), 64'd0, 4'(i + 8), 0,
           64'h1000 + 64'(i), 1'b0, 1'b0, 64'h1000 + 64'(i), 2'b00);
    end
    repeat (30) @(posedge i_clk);
    #1;
    check("t4_issued_4", 64'(issued - base), 64'd4);
    check("t4_rw_idle", 64'(o_rw), 64'd0);
    check("t4_busy", 64'(o_busy), 64'd1);
    check("t4_ready_2q", 64'(s_cmd_ready), 64'd1);
    for (int i = 6; i < 8; i++) begin
      send(1'b1, 3'd2, 32'h3000_0000 + 32'(i * 4), 64'd0, 4'(i + 8), 0,
           64'h1000 + 64'(i), 1'b0, 1'b0, 64'h1000 + 64'(i), 2'b00);
    end
    check("t4_ready_full", 64'(s_cmd_ready), 64'd0);
    m_rsp_ready = 1'b1;
    @(posedge i_clk); #1;
    m_rsp_ready = 1'b0;
    repeat (10) @(posedge i_clk);
    #1;
    check("t4_issued_5", 64'(issued - base), 64'd5);
    check("t4_ready_again", 64'(s_cmd_ready), 64'd1);
    m_rsp_ready = 1'b1;
    wait_idle("t4_idle");
    check("t4_issued_all", 64'(issued - base), 64'd8);

    // Error responses, then saturation from a preloaded count.
    for (int i = 0; i < 3; i++) begin
      send(1'b0, 3'd0, 32'h4000_0000 + 32'(i), 64'(i), 4'(i), 1,
           64'd0, 1'b1, 1'b0, 64'd0, 2'b01);
    end
    wait_idle("t5_idle_a");
    check("t5_err_count_4", 64'(o_err_count), 64'd4);
    force dut.err_cnt_r = 16'hFFFC;
    exp_err = 16'hFFFC;
    @(posedge i_clk); #1;
    release dut.err_cnt_r;
    check("t5_preload", 64'(o_err_count), 64'hFFFC);
    for (int i = 0; i < 3; i++) begin
      send(1'b1, 3'd1, 32'h4100_0000 + 32'(i * 2), 64'd0, 4'(i), 0,
           64'h77, 1'b1, 1'b0, 64'h77, 2'b01);
    end
    wait_idle("t5_idle_b");
    check("t5_err_max", 64'(o_err_count), 64'hFFFF);
    for (int i = 0; i < 2; i++) begin
      send(1'b0, 3'd2, 32'h4200_0000, 64'd1, 4'd2, 2,
           64'd0, 1'b1, 1'b0, 64'd0, 2'b01);
    end
    wait_idle("t5_idle_c");
    check("t5_err_sat", 64'(o_err_count), 64'(exp_err));

    // Reset while a transfer is outstanding with two commands queued.
    m_rsp_ready = 1'b0;
    send(1'b0, 3'd2, 32'h5000_0000, 64'h55, 4'd1, 0, 64'd0, 1'b0, 1'b0, 64'd0, 2'b00);
    send(1'b1, 3'd3, 32'h5000_0008, 64'd0, 4'd2, 40, 64'd9, 1'b0, 1'b0, 64'd9, 2'b00);
    send(1'b0, 3'd0, 32'h5000_0010, 64'h1, 4'd3, 0, 64'd0, 1'b0, 1'b0, 64'd0, 2'b00);
    send(1'b0, 3'd0, 32'h5000_0011, 64'h2, 4'd4, 0, 64'd0, 1'b0, 1'b0, 64'd0, 2'b00);
    repeat (8) @(posedge i_clk);
    #1;
    check("t6_pre_rsp_valid", 64'(m_rsp_valid), 64'd1);
    #2;
    i_rst = 1'b1;
    #1;
    check("t6_rst_rw", 64'(o_rw), 64'd0);
    check("t6_rst_rsp_valid", 64'(m_rsp_valid), 64'd0);
    check("t6_rst_cmd_ready", 64'(s_cmd_ready), 64'd1);
    check("t6_rst_err_count", 64'(o_err_count), 64'd0);
    check("t6_rst_busy", 64'(o_busy), 64'd0);
    plan_q.delete();
    sb_q.delete();
    exp_err = 16'd0;
    @(posedge i_clk); #1;
    i_rst = 1'b0;
    m_rsp_ready = 1'b1;
    @(posedge i_clk); #1;
    send(1'b0, 3'd2, 32'h6000_0000, 64'hCAFE_F00D, 4'd9, 2,
         64'hFFFF_0000_FFFF_0000, 1'b0, 1'b0, 64'd0, 2'b00);
    wait_idle("t6_idle");
    check("t6_err_count", 64'(o_err_count), 64'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
